// File: rtl/rows_inverse_stream_if.sv
// ---------------------------------------------------------------------------
// rows_inverse_stream_if
// Byte-serial handshake bundle for rows_inverse_stream.
//   in_valid  / in_ready   : input byte handshake (permuted state in)
//   in_data   [7:0]        : permuted-state byte, row-major
//   in_sel    [1:0]        : row-swap key field, meaningful with byte 0 only
//   out_valid / out_ready  : output byte handshake (restored state out)
//   out_data  [7:0]        : restored-state byte, row-major
//   out_last               : marks byte 15 of an output frame
// The slave modport is the block's view; master is the link/driver view.
// ---------------------------------------------------------------------------
interface rows_inverse_stream_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rows_inverse_stream.sv
// ---------------------------------------------------------------------------
// rows_inverse_stream
// Collects one 16-byte (4x4) cipher state byte by byte, then streams it back
// out with the whole-row swap of the forward row stage undone. The swap is
// chosen by the 2-bit key field captured with byte 0 of each frame.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (clears buffer, counters, key, FSM)
//   bus  : rows_inverse_stream_if.slave (input and output byte streams)
// The block alternates FILL (accept 16 bytes) and DRAIN (emit 16 bytes);
// all outputs depend only on registered state and out_ready.
// ---------------------------------------------------------------------------
module rows_inverse_stream (
    input  logic                   clk,
    input  logic                   rst,
    rows_inverse_stream_if.slave   bus
);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [3:0] rcnt_q, rcnt_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] buf_q [16];

    logic       in_ready_s;
    logic       out_valid_s;
    logic       in_fire;
    logic       out_fire;
    logic [1:0] src_row_s;
    logic [3:0] rd_idx;

    assign in_fire  = bus.in_valid & in_ready_s;
    assign out_fire = out_valid_s & bus.out_ready;

    // Source row (w=0, x=1, y=2, z=3) feeding output row r (a=0..d=3).
    // Each table packs src(d),src(c),src(b),src(a) from MSB to LSB.
    function automatic logic [1:0] src_row(input logic [1:0] sel, input logic [1:0] r);
        logic [7:0] tbl;
        tbl = 8'b11_00_01_10;
        case (sel)
            2'b00:   tbl = 8'b11_00_01_10; // a<-y b<-x c<-w d<-z
            2'b01:   tbl = 8'b01_10_11_00; // a<-w b<-z c<-y d<-x
            2'b10:   tbl = 8'b10_11_00_01; // a<-x b<-w c<-z d<-y
            default: tbl = 8'b00_01_10_11; // a<-z b<-y c<-x d<-w
        endcase
        return tbl[{r, 1'b0} +: 2];
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (in_fire && (wcnt_q == 4'hF))  state_d = DRAIN;
            DRAIN:   if (out_fire && (rcnt_q == 4'hF)) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_q)
            FILL:    in_ready_s  = 1'b1;
            DRAIN:   out_valid_s = 1'b1;
            default: in_ready_s  = 1'b0;
        endcase
    end

    // ---------------- counters and key capture ----------------
    // Counters are 4 bits, so the step past 15 wraps to 0 by itself.
    always_comb begin
        wcnt_d = wcnt_q;
        rcnt_d = rcnt_q;
        sel_d  = sel_q;
        if (in_fire) begin
            wcnt_d = wcnt_q + 4'd1;
            if (wcnt_q == 4'd0) begin
                sel_d = bus.in_sel;
            end
        end
        if (out_fire) begin
            rcnt_d = rcnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= 4'd0;
            rcnt_q <= 4'd0;
            sel_q  <= 2'b00;
        end else begin
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
            sel_q  <= sel_d;
        end
    end

    // ---------------- state buffer ----------------
    // One register per byte: the buffer must clear on reset and is read
    // combinationally at the permuted address, so it stays in flops.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_buf
            always_ff @(posedge clk) begin
                if (rst) begin
                    buf_q[gi] <= 8'h00;
                end else if (in_fire && (wcnt_q == 4'(gi))) begin
                    buf_q[gi] <= bus.in_data;
                end
            end
        end
    endgenerate

    // ---------------- read side ----------------
    assign src_row_s = src_row(sel_q, rcnt_q[3:2]);
    assign rd_idx    = {src_row_s, rcnt_q[1:0]};

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = buf_q[rd_idx];
    assign bus.out_last  = out_valid_s & (rcnt_q == 4'hF);

endmodule

// File: tb/tb_rows_inverse_stream.sv
// ---------------------------------------------------------------------------
// tb_rows_inverse_stream
// Randomized self-checking bench for rows_inverse_stream. A frame-level model
// (row table lookup on whole 16-byte arrays) produces the expected output
// stream; a cycle monitor tracks FILL/DRAIN occupancy from observed transfers
// and compares every handshake, data and stall property on each negedge.
// ---------------------------------------------------------------------------
module tb_rows_inverse_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rows_inverse_stream_if bus();

    rows_inverse_stream dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef logic [7:0] frame_t [16];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [8:0] exp_q [$];     // {last, data}
    logic [7:0] out_log [$];
    bit started   = 1'b0;
    bit rnd_ready = 1'b0;

    // Output row r of the restored state comes from source row src_map[sel][r].
    int src_map [4][4] = '{'{2, 1, 0, 3}, '{0, 3, 2, 1}, '{1, 0, 3, 2}, '{3, 2, 1, 0}};

    logic [7:0] pin_first [4] = '{8'h08, 8'h00, 8'h04, 8'h0C};
    logic [7:0] pin_row1  [4] = '{8'h04, 8'h0C, 8'h00, 8'h08};
    logic [7:0] pin_lastb [4] = '{8'h0F, 8'h07, 8'h0B, 8'h03};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void inv_model(input frame_t fin, input logic [1:0] sel, output frame_t fout);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                fout[4*r+c] = fin[4*src_map[sel][r]+c];
    endfunction

    function automatic void fwd_model(input frame_t fin, input logic [1:0] sel, output frame_t fout);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                fout[4*src_map[sel][r]+c] = fin[4*r+c];
    endfunction

    // ---------------- downstream ready ----------------
    always @(posedge clk) begin
        #1;
        bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- monitor / compare ----------------
    bit         m_drain    = 1'b0;
    int         m_in       = 0;
    int         m_out      = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    always @(negedge clk) begin
        if (started) begin
            if (rst) begin
                m_drain    = 1'b0;
                m_in       = 0;
                m_out      = 0;
                prev_stall = 1'b0;
            end else begin
                logic [8:0] e;
                check("in_ready", 8'(bus.in_ready), 8'(!m_drain));
                check("out_valid", 8'(bus.out_valid), 8'(m_drain));
                check("out_last_level", 8'(bus.out_last), 8'(m_drain && (m_out == 15)));
                if (prev_stall) begin
                    check("stall_data", bus.out_data, prev_data);
                    check("stall_last", 8'(bus.out_last), 8'(prev_last));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_out: got %h expected no byte at %0t", bus.out_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", bus.out_data, e[7:0]);
                        check("out_last", 8'(bus.out_last), 8'(e[8]));
                    end
                    out_log.push_back(bus.out_data);
                    $display("out byte %h last=%b t=%0t", bus.out_data, bus.out_last, $time);
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
                prev_last  = bus.out_last;
                if (!m_drain && bus.in_valid && bus.in_ready) begin
                    m_in++;
                    if (m_in == 16) begin
                        m_drain = 1'b1;
                        m_in    = 0;
                    end
                end else if (m_drain && bus.out_valid && bus.out_ready) begin
                    if (m_out == 15) begin
                        m_drain = 1'b0;
                        m_out   = 0;
                    end else begin
                        m_out++;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_frame(input frame_t f, input logic [1:0] sel, input bit tog,
                              input bit gaps, input int nbytes);
        frame_t ex;
        if (nbytes == 16) begin
            inv_model(f, sel, ex);
            for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), ex[i]});
        end
        for (int i = 0; i < nbytes; i++) begin
            int k;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = f[i];
            bus.in_sel   = (i == 0 || !tog) ? sel : 2'($urandom_range(0, 3));
            k = 0;
            forever begin
                @(negedge clk);
                if (bus.in_ready) break;
                k++;
                if (k > 200) begin
                    $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
                    $fatal(1, "input stalled");
                end
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drained();
        int k = 0;
        forever begin
            @(posedge clk); #2;
            if (exp_q.size() == 0 && !m_drain) break;
            k++;
            if (k > 3000) begin
                $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
                $fatal(1, "output stalled");
            end
        end
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", 8'(bus.in_ready), 8'h01);
        check("rst_out_valid", 8'(bus.out_valid), 8'h00);
        check("rst_out_last", 8'(bus.out_last), 8'h00);
        check("rst_out_data", bus.out_data, 8'h00);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        frame_t f, p, m;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_sel    = 2'b00;
        bus.out_ready = 1'b1;

        // Pin the model itself against hand-computed rows.
        for (int i = 0; i < 16; i++) f[i] = 8'(i);
        for (int s = 0; s < 4; s++) begin
            inv_model(f, 2'(s), m);
            check("model_first", m[0], pin_first[s]);
            check("model_row1", m[4], pin_row1[s]);
            check("model_lastbyte", m[15], pin_lastb[s]);
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        started = 1'b1;
        check_reset_values();

        // Incrementing frame with every key value, ready held high.
        for (int s = 0; s < 4; s++) begin
            out_log.delete();
            send_frame(f, 2'(s), 1'b0, 1'b0, 16);
            wait_drained();
            check("dut_first", out_log[0], pin_first[s]);
            check("dut_row1", out_log[4], pin_row1[s]);
            check("dut_lastbyte", out_log[15], pin_lastb[s]);
            $display("frame sel=%0d done", s);
        end

        // Key sampled on byte 0 only.
        out_log.delete();
        send_frame(f, 2'b11, 1'b1, 1'b0, 16);
        wait_drained();
        check("sel_hold_first", out_log[0], 8'h0C);
        $display("frame sel-toggle done");

        // Random backpressure and input gaps.
        rnd_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 16; i++) f[i] = 8'($urandom);
            send_frame(f, 2'($urandom_range(0, 3)), 1'b0, 1'b1, 16);
        end
        wait_drained();
        rnd_ready = 1'b0;
        $display("stalled frames done");

        // Reset mid-frame, then a clean frame.
        for (int i = 0; i < 16; i++) f[i] = 8'hA0 + 8'(i);
        send_frame(f, 2'b10, 1'b0, 1'b0, 7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_values();
        for (int i = 0; i < 16; i++) f[i] = 8'h10 + 8'(i);
        out_log.delete();
        send_frame(f, 2'b00, 1'b0, 1'b0, 16);
        wait_drained();
        check("post_rst_first", out_log[0], 8'h18);
        check("post_rst_row3", out_log[12], 8'h1C);
        $display("reset frame done");

        // Back-to-back round trip through the forward row stage.
        for (int n = 0; n < 6; n++) begin
            logic [1:0] s;
            s = 2'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++) f[i] = 8'($urandom);
            fwd_model(f, s, p);
            for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), f[i]});
            for (int i = 0; i < 16; i++) begin
                int k = 0;
                bus.in_valid = 1'b1;
                bus.in_data  = p[i];
                bus.in_sel   = s;
                forever begin
                    @(negedge clk);
                    if (bus.in_ready) break;
                    k++;
                    if (k > 200) begin
                        $display("FAIL rt_in_ready_timeout: got 0 expected 1 at %0t", $time);
                        $fatal(1, "input stalled");
                    end
                end
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b0;
            $display("round trip frame %0d sel=%0d sent", n, s);
        end
        wait_drained();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rows_inverse_stream.md
# rows_inverse_stream

Sequential inverse of the row-permutation stage of the cipher datapath. It collects one 4x4-byte state serially, undoes the whole-row swap selected by a 2-bit key field, and streams the restored state back out byte by byte. It sits on the decrypt path, between the byte-serial link and the upstream inverse stages, and consumes exactly what the forward row stage produces.

## Interface
- No parameters. State is fixed at 16 bytes (4 rows x 4 bytes); byte width is 8.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input byte present.
- in_ready  output  1  block accepts a byte this cycle.
- in_data  input  8  permuted-state byte, row-major: w0..w3, x0..x3, y0..y3, z0..z3.
- in_sel  input  2  {s3,s4} key field used by the forward stage; sampled only with byte 0.
- out_valid  output  1  output byte present.
- out_ready  input  1  downstream accepts the byte.
- out_data  output  8  restored-state byte, row-major: a0..a3, b0..b3, c0..c3, d0..d3.
- out_last  output  1  high with byte 15 of the output frame.

## Operation
- A transfer occurs on a rising edge when valid and ready are both high.
- Storage: 16-byte buffer buf[0..15], 4-bit input counter wcnt, 4-bit output counter rcnt, 2-bit sel_q register, and a 2-state FSM.
- FILL state:
  - in_ready = 1 and out_valid = 0.
  - Each input transfer writes buf[wcnt] and increments wcnt.
  - The transfer with wcnt = 0 also captures sel_q <= in_sel. in_sel is ignored on bytes 1-15.
  - The transfer with wcnt = 15 moves the FSM to DRAIN and wraps wcnt to 0.
- DRAIN state:
  - in_ready = 0 and out_valid = 1.
  - Output row r = rcnt[3:2] and column c = rcnt[1:0]; out_data = buf[4*src(r) + c].
  - Each output transfer increments rcnt.
  - The transfer with rcnt = 15 returns the FSM to FILL and wraps rcnt to 0.
- Inverse row map src(r) for r = a, b, c, d, with source rows w=0, x=1, y=2, z=3:
  - sel_q=00: a<-y, b<-x, c<-w, d<-z.
  - sel_q=01: a<-w, b<-z, c<-y, d<-x.
  - sel_q=10: a<-x, b<-w, c<-z, d<-y.
  - sel_q=11: a<-z, b<-y, c<-x, d<-w.
  - Every mapping is a pure row move; bytes within a row keep their order.
- out_last = out_valid & (rcnt == 15).
- Backpressure: while out_valid = 1 and out_ready = 0, out_data, out_last and rcnt hold.
- Input stall: an in_valid gap during FILL pauses wcnt; no timeout.
- Frames never overlap. No input is accepted during DRAIN.
- Reset, in any state and mid-frame: FSM <= FILL, wcnt = rcnt = 0, sel_q = 00, buf cleared to 0x00. A partial frame is discarded.

## Timing
- Reset values, in the cycle after rst is sampled high: in_ready = 1, out_valid = 0, out_last = 0, out_data = 0x00.
- Latency: out_valid rises the cycle after the 16th input transfer. First out_data is valid in that same cycle.
- in_ready rises the cycle after the out_last transfer.
- Peak throughput is 32 cycles per frame: 16 in plus 16 out, with no bubbles when valid and ready are held high.
- out_data, out_valid, out_last and in_ready are functions of registered state and out_ready only. There is no combinational path from in_valid or in_data to any output.

## Test plan
- Input 0x00..0x0F with in_sel=00, ready held high -> out 08..0B, 04..07, 00..03, 0C..0F. out_last is high on 0x0F. First out_valid is one cycle after the 16th input transfer.
- Same input stream with in_sel=01, 10, 11 -> out:
  - sel=01: 00..03, 0C..0F, 08..0B, 04..07.
  - sel=10: 04..07, 00..03, 0C..0F, 08..0B.
  - sel=11: 0C..0F, 08..0B, 04..07, 00..03.
- sel=11 on byte 0, then in_sel toggled on bytes 1-15 -> output still follows the sel=11 map.
- Random out_ready at 50% and random in_valid gaps -> byte sequence identical to the unstalled case. out_data is stable while stalled. in_ready stays 0 throughout DRAIN.
- rst asserted after 7 input bytes, then a full frame 0x10..0x1F with sel=00 -> out 18..1B, 14..17, 10..13, 1C..1F. No stale bytes appear.
- Back-to-back round trip: random 16-byte states and random sel passed through the forward row stage, then this block -> output equals the original state, and in_ready returns one cycle after each out_last transfer.
